// File: rtl/pkt_rx_parser_if.sv
// Bundle of the parser's stream input, cache write port and descriptor port.
// The statistics outputs exist only when PKT_RX_STAT_EN is defined.
interface pkt_rx_parser_if #(
  parameter int DW = 32
);
  logic          i_sop;
  logic          i_vld;
  logic [DW-1:0] i_data;
  logic          i_eop;
  logic          o_wr_en;
  logic [DW-1:0] o_wr_data;
  logic [3:0]    o_wr_da;
  logic          o_wr_last;
  logic          o_wr_abort;
  logic          o_desc_vld;
  logic [3:0]    o_desc_da;
  logic [2:0]    o_desc_prior;
  logic [9:0]    o_desc_len;
  logic          i_desc_rdy;
  logic          o_pkt_err;
  logic          o_pkt_drop;
`ifdef PKT_RX_STAT_EN
  logic [15:0]   o_good_cnt;
  logic [15:0]   o_err_cnt;
  logic [15:0]   o_drop_cnt;
`endif

  modport slave (
    input  i_sop, i_vld, i_data, i_eop, i_desc_rdy,
    output o_wr_en, o_wr_data, o_wr_da, o_wr_last, o_wr_abort,
    output o_desc_vld, o_desc_da, o_desc_prior, o_desc_len,
`ifdef PKT_RX_STAT_EN
    output o_good_cnt, o_err_cnt, o_drop_cnt,
`endif
    output o_pkt_err, o_pkt_drop
  );

  modport master (
    output i_sop, i_vld, i_data, i_eop, i_desc_rdy,
    input  o_wr_en, o_wr_data, o_wr_da, o_wr_last, o_wr_abort,
    input  o_desc_vld, o_desc_da, o_desc_prior, o_desc_len,
`ifdef PKT_RX_STAT_EN
    input  o_good_cnt, o_err_cnt, o_drop_cnt,
`endif
    input  o_pkt_err, o_pkt_drop
  );
endinterface

// File: rtl/pkt_rx_parser.sv
// Packet ingress parser: header decode, framing check, payload forwarding, descriptor FIFO.
// Define PKT_RX_STAT_EN to add saturating good/error/drop packet counters.
module pkt_rx_parser #(
  parameter int DW         = 32,
  parameter int DESC_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pkt_rx_parser_if.slave bus
);
  // state     | meaning
  // S_IDLE    | waiting for a header word
  // S_PAYLOAD | forwarding payload words of an accepted header
  // S_DROP    | discarding words until eop
  localparam int BSH = $clog2(DW / 8);
  localparam int AW  = $clog2(DESC_DEPTH);
  localparam int CW  = 11;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]    r_da, w_hdr_da, r_wr_da;
  logic [2:0]    r_prior, w_hdr_prior;
  logic [9:0]    r_len, w_hdr_len;
  logic [CW-1:0] r_exp, r_cnt, w_hdr_exp, w_cnt_inc;
  logic          w_wr_en, w_last, w_abort, w_err, w_drop, w_latch, w_push, w_push_hdr, w_late;
  logic          r_wr_en, r_wr_last, r_wr_abort, r_pkt_err, r_pkt_drop, r_late;
  logic [DW-1:0] r_wr_data;
  logic [16:0]   r_mem [DESC_DEPTH];
  logic [16:0]   w_desc_in, w_head;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_fcnt;
  logic          w_full, w_fne, w_pop, w_push_ok;

  assign w_hdr_da    = bus.i_data[3:0];
  assign w_hdr_prior = bus.i_data[6:4];
  assign w_hdr_len   = bus.i_data[16:7];
  assign w_hdr_exp   = (CW'(w_hdr_len) + CW'((DW / 8) - 1)) >> BSH;
  assign w_cnt_inc   = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_vld) begin
      if (bus.i_sop) begin
        if (bus.i_eop)   w_state_nxt = S_IDLE;
        else if (w_full) w_state_nxt = S_DROP;
        else             w_state_nxt = S_PAYLOAD;
      end else begin
        case (r_state)
          S_PAYLOAD: begin
            if (bus.i_eop)                w_state_nxt = S_IDLE;
            else if (w_cnt_inc >= r_exp)  w_state_nxt = S_DROP;
          end
          S_DROP:    if (bus.i_eop) w_state_nxt = S_IDLE;
          default:   w_state_nxt = r_state;
        endcase
      end
    end
  end

  always_comb begin
    w_wr_en    = 1'b0;
    w_last     = 1'b0;
    w_abort    = 1'b0;
    w_err      = 1'b0;
    w_drop     = 1'b0;
    w_latch    = 1'b0;
    w_push     = 1'b0;
    w_push_hdr = 1'b0;
    w_late     = 1'b0;
    if (bus.i_vld) begin
      if (bus.i_sop) begin
        if (r_state == S_PAYLOAD) begin
          w_abort = 1'b1;
          w_err   = 1'b1;
        end
        if (w_full) begin
          w_drop = 1'b1;
        end else begin
          w_latch = 1'b1;
          if (bus.i_eop) begin
            if (w_hdr_exp == '0) begin
              w_push     = 1'b1;
              w_push_hdr = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
        end
      end else begin
        case (r_state)
          S_IDLE: w_err = 1'b1;
          S_PAYLOAD: begin
            w_wr_en = 1'b1;
            if (bus.i_eop) begin
              if (w_cnt_inc == r_exp) begin
                w_last = 1'b1;
                w_push = 1'b1;
              end else begin
                w_abort = 1'b1;
                w_err   = 1'b1;
              end
            end else if (w_cnt_inc >= r_exp) begin
              w_late = 1'b1;
            end
          end
          default: w_wr_en = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_da    <= '0;
      r_prior <= '0;
      r_len   <= '0;
      r_exp   <= '0;
      r_cnt   <= '0;
    end else if (w_latch) begin
      r_da    <= w_hdr_da;
      r_prior <= w_hdr_prior;
      r_len   <= w_hdr_len;
      r_exp   <= w_hdr_exp;
      r_cnt   <= '0;
    end else if (w_wr_en) begin
      r_cnt   <= w_cnt_inc;
    end
  end

  // A missing eop is only known once the last expected word is written, so its abort trails by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_last  <= 1'b0;
      r_wr_abort <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_pkt_drop <= 1'b0;
      r_late     <= 1'b0;
      r_wr_data  <= '0;
      r_wr_da    <= '0;
    end else begin
      r_wr_en    <= w_wr_en;
      r_wr_last  <= w_last;
      r_wr_abort <= w_abort | r_late;
      r_pkt_err  <= w_err | r_late;
      r_pkt_drop <= w_drop;
      r_late     <= w_late;
      if (w_wr_en) begin
        r_wr_data <= bus.i_data;
        r_wr_da   <= r_da;
      end
    end
  end

  assign w_full    = (r_fcnt == (AW + 1)'(DESC_DEPTH));
  assign w_fne     = (r_fcnt != '0);
  assign w_pop     = w_fne & bus.i_desc_rdy;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_desc_in = w_push_hdr ? {w_hdr_da, w_hdr_prior, w_hdr_len} : {r_da, r_prior, r_len};
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_desc_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop)      r_fcnt <= r_fcnt + (AW + 1)'(1);
      else if (!w_push_ok && w_pop) r_fcnt <= r_fcnt - (AW + 1)'(1);
    end
  end

  assign bus.o_wr_en      = r_wr_en;
  assign bus.o_wr_data    = r_wr_data;
  assign bus.o_wr_da      = r_wr_da;
  assign bus.o_wr_last    = r_wr_last;
  assign bus.o_wr_abort   = r_wr_abort;
  assign bus.o_pkt_err    = r_pkt_err;
  assign bus.o_pkt_drop   = r_pkt_drop;
  assign bus.o_desc_vld   = w_fne;
  assign bus.o_desc_da    = w_fne ? w_head[16:13] : 4'd0;
  assign bus.o_desc_prior = w_fne ? w_head[12:10] : 3'd0;
  assign bus.o_desc_len   = w_fne ? w_head[9:0]   : 10'd0;

`ifdef PKT_RX_STAT_EN
  logic [15:0] r_good_cnt, r_err_cnt, r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_ok && r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_pkt_err && r_err_cnt != 16'hFFFF)  r_err_cnt  <= r_err_cnt + 16'd1;
      if (r_pkt_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.o_good_cnt = r_good_cnt;
  assign bus.o_err_cnt  = r_err_cnt;
  assign bus.o_drop_cnt = r_drop_cnt;
`endif
endmodule
